// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: register-file write-back controller.
// Arbitrates between the ALU and load/POP write-back requests and turns each
// accepted request into one (byte) or two (word, low then high byte) registered
// writes on the single 8-bit register-file write port. Also flags decode-stage
// read-after-write hazards against the write on the port and a pending high byte.
module rf_wb_ctrl #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_req,
  input  logic        alu_word,
  input  logic [4:0]  alu_addr,
  input  logic [15:0] alu_data,
  output logic        alu_ack,
  input  logic        ld_req,
  input  logic [4:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ack,
  output logic        FR_WE,
  output logic [4:0]  FR_Waddr,
  output logic [7:0]  FR_Wdata,
  input  logic [4:0]  FR_RAddr_1,
  input  logic [4:0]  FR_RAddr_2,
  output logic        hz_1,
  output logic        hz_2,
  output logic        wb_busy
);

  typedef enum logic {IDLE = 1'b0, HI = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       grant_alu, grant_ld;
  logic       prefer_ld;   // 1 = load wins the next contested grant
  logic [4:0] hi_addr;     // odd half of the register pair being written
  logic [7:0] hi_data;
  logic       contested;

  assign contested = (state == IDLE) && alu_req && ld_req;

  // State register: HI holds for exactly one cycle after a word acceptance.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Arbitration and next state: one acceptance per cycle, only from IDLE.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    case (state)
      IDLE: begin
        if (alu_req && ld_req) begin
          if (RR_EN && prefer_ld) grant_ld  = 1'b1;
          else                    grant_alu = 1'b1;
        end else if (alu_req) begin
          grant_alu = 1'b1;
        end else if (ld_req) begin
          grant_ld = 1'b1;
        end
        if (grant_alu && alu_word) state_nxt = HI;
      end
      HI:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Acks are combinational in the acceptance cycle; held low while in reset.
  assign alu_ack = grant_alu & ~rst;
  assign ld_ack  = grant_ld  & ~rst;

  // Write port and pending high byte: accepted data appears one cycle later,
  // the high byte of a word one cycle after that. Address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      FR_WE     <= 1'b0;
      FR_Waddr  <= 5'd0;
      FR_Wdata  <= 8'd0;
      hi_addr   <= 5'd0;
      hi_data   <= 8'd0;
      prefer_ld <= 1'b0;
    end else begin
      FR_WE <= 1'b0;
      if (grant_alu) begin
        FR_WE    <= 1'b1;
        FR_Waddr <= alu_word ? {alu_addr[4:1], 1'b0} : alu_addr;
        FR_Wdata <= alu_data[7:0];
        hi_addr  <= {alu_addr[4:1], 1'b1};
        hi_data  <= alu_data[15:8];
      end else if (grant_ld) begin
        FR_WE    <= 1'b1;
        FR_Waddr <= ld_addr;
        FR_Wdata <= ld_data;
      end else if (state == HI) begin
        FR_WE    <= 1'b1;
        FR_Waddr <= hi_addr;
        FR_Wdata <= hi_data;
      end
      // Round-robin pointer moves only when both requesters competed.
      if (contested) prefer_ld <= grant_alu;
    end
  end

  // Hazard flags: match against the write on the port or the queued high byte.
  assign hz_1 = (FR_WE && (FR_RAddr_1 == FR_Waddr)) ||
                ((state == HI) && (FR_RAddr_1 == hi_addr));
  assign hz_2 = (FR_WE && (FR_RAddr_2 == FR_Waddr)) ||
                ((state == HI) && (FR_RAddr_2 == hi_addr));

  // Busy while the low byte of a word is on the port and the high byte waits.
  assign wb_busy = (state == HI);

endmodule

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 SHALL provide parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed ALU priority.
REQ-002 SHALL provide port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL provide port alu_req, input, 1, ALU write-back request, held until acknowledged.
REQ-005 SHALL provide port alu_word, input, 1, 1 = 16-bit register-pair write, 0 = byte write.
REQ-006 SHALL provide port alu_addr, input, 5, destination register.
REQ-007 SHALL provide port alu_data, input, 16, write data; low byte used for byte writes.
REQ-008 SHALL provide port alu_ack, output, 1, one-cycle accept pulse for ALU request.
REQ-009 SHALL provide port ld_req, input, 1, load/POP write-back request, held until acknowledged.
REQ-010 SHALL provide port ld_addr, input, 5, destination register.
REQ-011 SHALL provide port ld_data, input, 8, write data.
REQ-012 SHALL provide port ld_ack, output, 1, one-cycle accept pulse for load request.
REQ-013 SHALL provide port FR_WE, output, 1, register-file write enable.
REQ-014 SHALL provide port FR_Waddr, output, 5, register-file write address.
REQ-015 SHALL provide port FR_Wdata, output, 8, register-file write data.
REQ-016 SHALL provide ports FR_RAddr_1 and FR_RAddr_2, input, 5 each, decode-stage read addresses.
REQ-017 SHALL provide ports hz_1 and hz_2, output, 1 each, read-after-write hazard flags.
REQ-018 SHALL provide port wb_busy, output, 1, high while a word write high byte is pending.

Function
REQ-019 SHALL implement FSM states IDLE and HI; a word acceptance moves IDLE->HI, HI returns to IDLE after one cycle.
REQ-020 SHALL accept at most one request per cycle, only in IDLE; no acceptance in HI.
REQ-021 SHALL assert the accepting ack in the acceptance cycle N, sampling addr/data that cycle.
REQ-022 SHALL drive FR_WE/FR_Waddr/FR_Wdata from registers: byte write appears in cycle N+1 only.
REQ-023 SHALL for word writes drive low byte to {addr[4:1],0} in N+1 and high byte to {addr[4:1],1} in N+2; addr[0] ignored.
REQ-024 SHALL sustain one byte write per cycle with back-to-back requests (acceptance in cycle N+1 while N write is on the port).
REQ-025 SHALL with RR_EN=1 and both requests in IDLE grant the requester not granted last; pointer updates only on a contested grant.
REQ-026 SHALL with RR_EN=0 always grant ALU over load when both pending.
REQ-027 SHALL deassert FR_WE in any cycle with no write scheduled; FR_Waddr/FR_Wdata hold last value.
REQ-028 SHALL assert hz_k combinationally when FR_RAddr_k equals FR_Waddr with FR_WE high, or equals the pending high-byte address in HI.
REQ-029 SHALL drive wb_busy high exactly during HI state, and for the cycle of the low-byte write.
REQ-030 SHALL never assert alu_ack and ld_ack in the same cycle.
REQ-031 SHALL ignore a request deasserted before acknowledgment (no write generated).

Reset
REQ-032 SHALL on rst asynchronously force IDLE, FR_WE=0, FR_Waddr=0, FR_Wdata=0, alu_ack=0, ld_ack=0, wb_busy=0, round-robin pointer favouring ALU.
REQ-033 SHALL on rst asserted mid word write drop the pending high byte; no write after reset release until a new acceptance.

Verification
REQ-034 SHALL cover: alu_req byte addr=5 data=0x3C -> alu_ack cycle N, FR_WE=1 addr=5 data=0x3C cycle N+1 only.
REQ-035 SHALL cover: alu_word addr=25 data=0xBEEF -> writes 24<=0xEF (N+1), 25<=0xBE (N+2), ld_req held during N+1 acked in N+2 at earliest... acked no earlier than IDLE return, write at N+3.
REQ-036 SHALL cover: RR_EN=1, alu_req and ld_req held 4 cycles continuously -> acks alternate ALU, LD, ALU, LD; RR_EN=0 -> ALU acked every cycle, ld_ack never.
REQ-037 SHALL cover: FR_RAddr_1=17 while word write to 16/17 low byte on port -> hz_1=1 in N+1 and N+2; FR_RAddr_2=3 -> hz_2=0.
REQ-038 SHALL cover: rst pulsed in cycle N+1 of word write to 30 -> no write to 31, all outputs zero, next byte request processed normally.
